seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised Mealy serial-pattern detector. It compares a 1-bit input stream, qualified by `x_valid`, against a runtime-programmable pattern of 1..MAX_LEN bits. It flags each match on `z` in the same cycle as the final pattern bit. Overlapping or non-overlapping detection is selectable, and a saturating match counter is included. It sits after a serial input capture stage and before the event/interrupt logic of the sequential-logic group.

## Interface

- `MAX_LEN`, default 8: maximum pattern length in bits; legal range 2..32.
- `CNT_W`, default 16: width of the match counter.
- `LW`, default $clog2(MAX_LEN+1): width of `cfg_len`. Derived; do not override.

Ports:

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_load`  in  1  load the configuration below at this edge.
- `cfg_pattern`  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- `cfg_len`  in  LW  pattern length; legal 1..MAX_LEN.
- `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `x`  in  1  serial data bit.
- `x_valid`  in  1  `x` is a valid stream bit this cycle.
- `z`  out  1  Mealy match flag; combinational from `x`/`x_valid` and state.
- `match_cnt`  out  CNT_W  number of matches since reset; saturating.
- `cfg_err`  out  1  sticky flag: last load attempt had an illegal `cfg_len`.

## Operation

- State registers: `pat` (MAX_LEN), `len` (LW), `ovl` (1), `hist` (MAX_LEN-1, shift register of past valid bits), `fill` (0..MAX_LEN-1, saturating count of valid history bits), `match_cnt`, `cfg_err`.
- Reset values:
  - `pat` = 110 in the low 3 bits, zeros elsewhere; `len` = 3; `ovl` = 1.
  - `hist` = 0, `fill` = 0, `match_cnt` = 0, `cfg_err` = 0.
  - `z` = 0 while reset is asserted.
- Window: `{hist[len-2:0], x}` is compared with `pat[len-1:0]`. For len = 1 the window is `x` alone.
- `z` = `x_valid` & ~`cfg_load` & ~`reset` & (`fill` >= `len`-1) & (window == `pat[len-1:0]`).
- Valid bit (`x_valid`=1, `cfg_load`=0):
  - `hist` <= {`hist`, `x`}, i.e. shift left and insert `x` at bit 0.
  - `fill` <= min(`fill`+1, MAX_LEN-1).
- Bits with `x_valid`=0 are invisible: no shift, no `fill` change, `z`=0. Gaps never break a partial match.
- On match with `ovl`=1: `fill` advances normally, so the suffix of a match can begin the next match.
- On match with `ovl`=0: `fill` <= 0. The next match needs `len` fresh valid bits. `hist` still shifts.
- `match_cnt` increments by 1 on every cycle with `z`=1. It holds at 2^CNT_W-1 and never wraps.
- Configuration load (`cfg_load`=1):
  - If 1 <= `cfg_len` <= MAX_LEN: latch `pat`, `len`, `ovl`; `fill` <= 0; `cfg_err` <= 0.
  - Otherwise the configuration is unchanged, `fill` is unchanged, and `cfg_err` <= 1.
  - `cfg_load` takes priority over `x_valid`: that cycle's bit is dropped and `z`=0.
  - `match_cnt` is never cleared by a load.
- `cfg_err` stays set until a legal load or reset.

## Timing

- `z` has zero latency. It is asserted in the same cycle as the last pattern bit is presented, and is valid before the edge that consumes that bit.
- `match_cnt` reflects a match one cycle after `z`.
- A new configuration applies to valid bits from the cycle after the `cfg_load` edge.
- `cfg_err` updates one cycle after the load.
- Reset is asynchronous. Assertion mid-stream immediately clears all state, aborts any partial match, and forces `z`=0. Release must be synchronous to `clk` in the system.
- Back-to-back valid bits every cycle are supported. Throughput is 1 bit/clk.

## Test plan

- Default configuration after reset, x = 1,1,0 all valid → `z`=1 only on the 3rd bit. Then x = 1,1,1,0 → `z`=1 only on the 4th bit; `match_cnt`=2.
- Load `cfg_pattern`=101, `cfg_len`=3, `cfg_overlap`=1, then x = 1,0,1,0,1 → `z` on bits 3 and 5. Reload with `cfg_overlap`=0 and send the same stream → `z` on bit 3 only.
- Default configuration, stream 1,(`x_valid`=0 with x=0),1,(`x_valid`=0),0 → `z`=1 on the final valid bit and never during the gaps.
- Load `cfg_len`=0 → `cfg_err`=1 next cycle; 1,1,0 still matches. Load `cfg_len`=MAX_LEN+1 → same result. Then a legal load → `cfg_err`=0.
- With CNT_W=4 and pattern 1 (len 1), drive 20 valid ones → `match_cnt` reads 15 and holds.
- Default configuration, x = 1,1, assert `reset` asynchronously mid-cycle, release, then x = 0 → `z` stays 0. Then send 1,1,0 → `z`=1 on its 3rd bit.

Source files
------------

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (Mealy) with selectable overlap
// handling, a saturating match counter and a sticky illegal-length flag.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               x,
  input  logic               x_valid,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam int HW = MAX_LEN - 1;
  localparam int FW = $clog2(MAX_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(MAX_LEN - 1);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [HW-1:0]      hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] window;
  logic               hit;
  logic               filled;
  logic               cfg_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // Newest bit sits at window[0]; only the low len bits take part in the compare.
  assign window = {hist_q, x};
  assign hit    = ((window ^ pat_q) & len_mask) == '0;
  assign filled = (int'(fill_q) + 1) >= int'(len_q);
  assign cfg_ok = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);
  assign z      = x_valid & ~cfg_load & ~reset & filled & hit;

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (cfg_load) begin
      if (cfg_ok) begin
        pat_d  = cfg_pattern;
        len_d  = cfg_len;
        ovl_d  = cfg_overlap;
        fill_d = '0;
        err_d  = 1'b0;
      end else begin
        err_d  = 1'b1;
      end
    end else if (x_valid) begin
      hist_d = HW'({hist_q, x});
      // Non-overlapping mode discards the bits of a completed match.
      if (z && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FW'(1);
      end
    end
    if (z) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= MAX_LEN'(3'b110);
      len_q  <= LW'(3);
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;

endmodule
